stream_fifo: RTL
================

// Module: stream_fifo
// PURPOSE
//  Parametrised valid/ready stream FIFO, first-word-fall-through, arbitrary (non-power-of-2) depth.
//  Buffers DATA_WIDTH-bit words between a producer and a consumer in one clock domain.
//  Provides occupancy count, programmable almost-full/almost-empty flags and a synchronous clear.
//  Drop-in elastic buffer for any stream interface in the design.
// PARAMETERS
//  DATA_WIDTH    8   width of each stored word, >= 1
//  DEPTH         4   number of entries, >= 2, any integer
//  AF_THRESHOLD  3   almost_full_o asserts when count >= AF_THRESHOLD (1..DEPTH)
//  AE_THRESHOLD  1   almost_empty_o asserts when count <= AE_THRESHOLD (0..DEPTH-1)
//  CNT_W (localparam) = $clog2(DEPTH+1);  PTR_W (localparam) = max(1, $clog2(DEPTH))
// PORTS
//  clk_i             in   1           clock, all logic on rising edge
//  arst_ni           in   1           asynchronous active-low reset
//  clear_i           in   1           synchronous flush, active-high
//  data_in_i         in   DATA_WIDTH  write data
//  data_in_valid_i   in   1           producer has a word
//  data_in_ready_o   out  1           FIFO can accept a word
//  data_out_o        out  DATA_WIDTH  head word (valid only when data_out_valid_o)
//  data_out_valid_o  out  1           head word available
//  data_out_ready_i  in   1           consumer takes head word
//  count_o           out  CNT_W       current occupancy 0..DEPTH
//  almost_full_o     out  1           count_o >= AF_THRESHOLD
//  almost_empty_o    out  1           count_o <= AE_THRESHOLD
// BEHAVIOUR
//  - One clock clk_i; reset arst_ni asynchronous, active-low; deassertion synchronous to clk_i.
//  - Reset: wr_ptr=rd_ptr=0, count=0 -> data_in_ready_o=1, data_out_valid_o=0, count_o=0,
//    almost_full_o=0, almost_empty_o=1; data_out_o = stale mem content (don't-care, no reset of mem).
//  - push = data_in_valid_i & data_in_ready_o; pop = data_out_valid_o & data_out_ready_i.
//  - data_in_ready_o = (count != DEPTH); no combinational path from data_out_ready_i (full FIFO
//    refuses a push even if a pop occurs that cycle).
//  - data_out_valid_o = (count != 0); data_out_o = mem[rd_ptr] combinationally (FWFT).
//  - Latency: word pushed in cycle N is visible at data_out_o in cycle N+1 (empty FIFO).
//  - Push: mem[wr_ptr] <= data_in_i; wr_ptr advances. Pop: rd_ptr advances.
//  - Pointer wrap: ptr == DEPTH-1 -> 0 (explicit compare, not modulo 2^PTR_W).
//  - count: push&!pop -> +1; pop&!push -> -1; both or neither -> unchanged.
//  - Empty + push + data_out_ready_i: no pop that cycle (valid is 0); word appears next cycle.
//  - clear_i: next edge wr_ptr=rd_ptr=count=0; overrides push/pop in same cycle (both discarded);
//    flags/ready follow count (registered state only, outputs derived combinationally).
//  - Reset asserted mid-transfer: all state cleared immediately; in-flight words are lost.
//  - Flags are combinational from registered count; no glitch-sensitive use assumed.
//  - SIMULATION-only initial checks: DEPTH<2 -> $fatal; AF_THRESHOLD outside 1..DEPTH or
//    AE_THRESHOLD outside 0..DEPTH-1 -> yellow warning via $display with %m.
// STRUCTURE
//  - No shared package needed; CNT_W/PTR_W are localparams in the module.
//  - One sub-module: wrap_counter #(.MAX(DEPTH-1)) (clk_i, arst_ni, clear_i, en_i, cnt_o),
//    instantiated twice for wr_ptr and rd_ptr.
//  - Storage: logic [DATA_WIDTH-1:0] mem [DEPTH] in flops, no reset.
// TESTING
//  - Reset: arst_ni low mid-cycle -> outputs immediately ready=1, valid=0, count=0, ae=1, af=0.
//  - DEPTH=5: push 0x11..0x15 with out_ready=0 -> count 5, ready=0, af=1; 6th push ignored;
//    drain -> 0x11..0x15 in order, count returns to 0.
//  - DEPTH=5 wrap: 13 push/pop cycles at 50% occupancy -> no data loss, order preserved across wrap.
//  - Simultaneous push+pop at count=2 -> count stays 2; at count=5 push refused, pop ok -> count 4.
//  - clear_i with count=3 and push+pop asserted -> next cycle count=0, valid=0, pushed word discarded.
//  - Empty, push 0xA5 with out_ready=1 -> valid=0 same cycle, valid=1 data_out_o=0xA5 next cycle.

Source files
------------

// File: rtl/stream_fifo_pkg.sv
// Shared types and helpers for the stream FIFO slice.
// Holds the per-cycle transfer encoding and pointer-width sizing.
package stream_fifo_pkg;

    // Bit 0 = push, bit 1 = pop; lets the occupancy update decode both at once.
    typedef enum logic [1:0] {
        OpNone = 2'b00,
        OpPush = 2'b01,
        OpPop  = 2'b10,
        OpBoth = 2'b11
    } fifo_op_e;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo_wrap_counter.sv
// Modulo-(MAX+1) counter used as a FIFO pointer.
// Wraps with an explicit compare, so depths need not be powers of two.
module wrap_counter #(
    parameter int unsigned MAX = 3,
    parameter int unsigned W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
    input  logic         clk_i,
    input  logic         arst_ni,
    input  logic         clear_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (clear_i) begin
            w_cnt_next = '0;
        end else if (en_i) begin
            w_cnt_next = (r_cnt == W'(MAX)) ? '0 : r_cnt + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO of arbitrary depth with occupancy count,
// almost-full/almost-empty flags and a synchronous clear that wins over push/pop.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned AF_THRESHOLD = 3,
    parameter int unsigned AE_THRESHOLD = 1
) (
    input  logic                          clk_i,
    input  logic                          arst_ni,
    input  logic                          clear_i,
    input  logic [DATA_WIDTH-1:0]         data_in_i,
    input  logic                          data_in_valid_i,
    output logic                          data_in_ready_o,
    output logic [DATA_WIDTH-1:0]         data_out_o,
    output logic                          data_out_valid_o,
    input  logic                          data_out_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic                          almost_full_o,
    output logic                          almost_empty_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = ptr_width(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]      r_count;
    logic [PTR_W-1:0]      w_wr_ptr;
    logic [PTR_W-1:0]      w_rd_ptr;
    logic                  w_push;
    logic                  w_pop;
    fifo_op_e              w_op;

    // Ready depends only on registered count: a full FIFO refuses even when popping.
    assign data_in_ready_o  = (r_count != CNT_W'(DEPTH));
    assign data_out_valid_o = (r_count != '0);
    assign data_out_o       = r_mem[w_rd_ptr];
    assign count_o          = r_count;
    assign almost_full_o    = (r_count >= CNT_W'(AF_THRESHOLD));
    assign almost_empty_o   = (r_count <= CNT_W'(AE_THRESHOLD));

    assign w_push = data_in_valid_i & data_in_ready_o;
    assign w_pop  = data_out_valid_o & data_out_ready_i;
    assign w_op   = fifo_op_e'({w_pop, w_push});

    wrap_counter #(
        .MAX (DEPTH - 1),
        .W   (PTR_W)
    ) u_wr_ptr (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .clear_i (clear_i),
        .en_i    (w_push),
        .cnt_o   (w_wr_ptr)
    );

    wrap_counter #(
        .MAX (DEPTH - 1),
        .W   (PTR_W)
    ) u_rd_ptr (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .clear_i (clear_i),
        .en_i    (w_pop),
        .cnt_o   (w_rd_ptr)
    );

    // Storage is deliberately not reset; contents are don't-care while empty.
    always_ff @(posedge clk_i) begin
        if (w_push && !clear_i) begin
            r_mem[w_wr_ptr] <= data_in_i;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else begin
            unique case (w_op)
                OpPush:  r_count <= r_count + CNT_W'(1);
                OpPop:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    initial begin
        if (DEPTH < 2) begin
            $fatal(1, "%m: DEPTH must be >= 2 (got %0d)", DEPTH);
        end
        if (AF_THRESHOLD < 1 || AF_THRESHOLD > DEPTH) begin
            $display("\033[33mWarning: %m: AF_THRESHOLD %0d outside 1..%0d\033[0m",
                     AF_THRESHOLD, DEPTH);
        end
        if (AE_THRESHOLD > DEPTH - 1) begin
            $display("\033[33mWarning: %m: AE_THRESHOLD %0d outside 0..%0d\033[0m",
                     AE_THRESHOLD, DEPTH - 1);
        end
    end

    a_count_bound: assert property (@(posedge clk_i) disable iff (!arst_ni)
        r_count <= CNT_W'(DEPTH));
`endif

endmodule
